// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial add engine.
//   - state_e   : controller state encoding (2'd3 is illegal and never entered)
//   - STATE_W   : width of the state register
//   - cnt_bits  : width of a bit counter that can hold the value w without wrap
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for an operation of w bits; sized so the count never wraps.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Single-bit full-adder cell, purely combinational.
//   Ports:
//     a, b  in   operand bits
//     cin   in   carry in
//     sum   out  a ^ b ^ cin
//     cout  out  majority(a, b, cin)
// -----------------------------------------------------------------------------
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add engine wrapped around one full-adder cell. Operands are
//   accepted on a valid/ready handshake, fed to the cell LSB first at one bit
//   pair per cycle with the carry registered between bits, and the WIDTH-bit
//   sum plus carry-out is returned on a valid/ready output handshake.
//
//   Parameters:
//     WIDTH      operand/sum width in bits, 1..64
//   Ports:
//     clk        in   clock, all state changes on the rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   operand request valid
//     in_ready   out  engine can accept operands (IDLE only)
//     in_a       in   operand A
//     in_b       in   operand B
//     in_cin     in   carry-in for bit 0
//     out_valid  out  result valid (DONE only)
//     out_ready  in   consumer accepts result
//     out_sum    out  in_a + in_b + in_cin modulo 2^WIDTH
//     out_cout   out  carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned      CNT_W    = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  // ---------------------------------------------------------------------------
  // Full-adder cell. The only feedback path (cout -> cin) is broken by c_q.
  // ---------------------------------------------------------------------------
  adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
  // result has arrived at sum_sr[0]. A 1-bit engine has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_sum;
    end else begin : g_sum_wn
      assign sum_shift = {fa_sum, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge only, so rst_n is not in the
  // sensitivity list; an asynchronous edge on rst_n has no effect until clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs, decoded from the state register
  // only (out_valid never looks at out_ready).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      // Illegal encoding: fall back to IDLE on the next edge.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shift registers, carry, bit counter, result registers.
  // Nothing moves in DONE, so the presented result is held under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= in_a;
      b_sr  <= in_b;
      c_q   <= in_cin;
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_shift;
      c_q    <= fa_cout;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        cout_q <= fa_cout;
      end
    end
  end

  assign out_sum  = sum_sr;
  assign out_cout = cout_q;

endmodule
